// File: rtl/adf4159_spi_receiver_pkg.sv
// Shared ADF4159 definitions: register-file layout, register addresses,
// bank-select bit positions and the commit decode used by the serial receiver.
package adf4159_spi_receiver_pkg;

  localparam logic [2:0] ADF4159_R0 = 3'd0;
  localparam logic [2:0] ADF4159_R1 = 3'd1;
  localparam logic [2:0] ADF4159_R2 = 3'd2;
  localparam logic [2:0] ADF4159_R3 = 3'd3;
  localparam logic [2:0] ADF4159_R4 = 3'd4;
  localparam logic [2:0] ADF4159_R5 = 3'd5;
  localparam logic [2:0] ADF4159_R6 = 3'd6;
  localparam logic [2:0] ADF4159_R7 = 3'd7;

  // R4 clock-divider select, R5 deviation select, R6 step select
  localparam int ADF4159_R4_BANK_BIT = 6;
  localparam int ADF4159_R5_BANK_BIT = 23;
  localparam int ADF4159_R6_BANK_BIT = 23;

  localparam logic [5:0] ADF4159_FRAME_BITS   = 6'd32;
  localparam logic [5:0] ADF4159_OVERRUN_BITS = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN
  } adf4159_rx_state_e;

  typedef struct packed {
    logic [31:0]      R0;
    logic [31:0]      R1;
    logic [31:0]      R2;
    logic [31:0]      R3;
    logic [1:0][31:0] R4;
    logic [1:0][31:0] R5;
    logic [1:0][31:0] R6;
    logic [31:0]      R7;
  } ADF4159_REGS;

  function automatic ADF4159_REGS adf4159_write(input ADF4159_REGS regs,
                                                input logic [31:0] word);
    ADF4159_REGS r;
    r = regs;
    case (word[2:0])
      ADF4159_R0: r.R0 = word;
      ADF4159_R1: r.R1 = word;
      ADF4159_R2: r.R2 = word;
      ADF4159_R3: r.R3 = word;
      ADF4159_R4: r.R4[word[ADF4159_R4_BANK_BIT]] = word;
      ADF4159_R5: r.R5[word[ADF4159_R5_BANK_BIT]] = word;
      ADF4159_R6: r.R6[word[ADF4159_R6_BANK_BIT]] = word;
      default:    r.R7 = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adf4159_spi_receiver_edge_sync.sv
// Synchroniser chain, one delay stage and a registered rising-edge strobe for
// one asynchronous serial pin.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;

  // level_o is the delayed copy so a data pin lines up with a clock pin's strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/adf4159_spi_receiver.sv
// Sniffs the ADF4159 three-wire write stream and rebuilds its register file,
// reporting committed words, a saturating good-frame count and framing errors.
module adf4159_spi_receiver
  import adf4159_spi_receiver_pkg::*;
#(
  parameter int Sync_Stages = 2
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipSPI_SClk,
  input  logic        ipSPI_Data,
  input  logic        ipSPI_Latch,
  input  logic        ipClear,
  output logic [31:0] opWord,
  output logic        opValid,
  output ADF4159_REGS opRegs,
  output logic [15:0] opWordCount,
  output logic        opFrameError,
  output logic        opErrorSticky
);

  logic sclk_lvl, sclk_rise;
  logic data_lvl, data_rise;
  logic latch_lvl, latch_rise;

  spi_edge_sync #(.STAGES(Sync_Stages)) u_sync_sclk (
    .clk_i(ipClk), .rst_ni(ipReset), .d_i(ipSPI_SClk),
    .level_o(sclk_lvl), .rise_o(sclk_rise)
  );

  spi_edge_sync #(.STAGES(Sync_Stages)) u_sync_data (
    .clk_i(ipClk), .rst_ni(ipReset), .d_i(ipSPI_Data),
    .level_o(data_lvl), .rise_o(data_rise)
  );

  spi_edge_sync #(.STAGES(Sync_Stages)) u_sync_latch (
    .clk_i(ipClk), .rst_ni(ipReset), .d_i(ipSPI_Latch),
    .level_o(latch_lvl), .rise_o(latch_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, data_rise, latch_lvl};

  adf4159_rx_state_e state_q, state_d;
  logic [5:0]        bitcnt_q, bitcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  ADF4159_REGS       regs_q, regs_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              sticky_q, sticky_d;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    regs_d       = regs_q;
    word_count_d = word_count_q;
    sticky_d     = sticky_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;

    // Shift first so a coincident latch sees the updated bit count
    if (sclk_rise) begin
      case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (bitcnt_q == ADF4159_FRAME_BITS) begin
            bitcnt_d = ADF4159_OVERRUN_BITS;
            state_d  = ST_OVERRUN;
          end else begin
            shift_d  = {shift_q[30:0], data_lvl};
            bitcnt_d = bitcnt_q + 6'd1;
            state_d  = ST_SHIFT;
          end
        end
        default: ;
      endcase
    end

    if (latch_rise) begin
      if (bitcnt_d == ADF4159_FRAME_BITS) begin
        word_d  = shift_d;
        regs_d  = adf4159_write(regs_q, shift_d);
        valid_d = 1'b1;
        if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
      end else begin
        ferr_d   = 1'b1;
        sticky_d = 1'b1;
      end
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      shift_d  = '0;
    end

    if (ipClear) begin
      word_count_d = '0;
      sticky_d     = 1'b0;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      regs_q       <= '0;
      word_count_q <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      regs_q       <= regs_d;
      word_count_q <= word_count_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
      sticky_q     <= sticky_d;
    end
  end

  assign opWord        = word_q;
  assign opValid       = valid_q;
  assign opRegs        = regs_q;
  assign opWordCount   = word_count_q;
  assign opFrameError  = ferr_q;
  assign opErrorSticky = sticky_q;

endmodule

// File: tb/tb_adf4159_spi_receiver.sv
// Directed bench for the ADF4159 serial receiver: frames, banks, framing
// errors, coincident edges, mid-frame reset, saturation and clear.
module tb_adf4159_spi_receiver;
  import adf4159_spi_receiver_pkg::*;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic        ipSPI_SClk;
  logic        ipSPI_Data;
  logic        ipSPI_Latch;
  logic        ipClear;
  logic [31:0] opWord;
  logic        opValid;
  ADF4159_REGS opRegs;
  logic [15:0] opWordCount;
  logic        opFrameError;
  logic        opErrorSticky;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int ferr_seen = 0;
  ADF4159_REGS exp_regs;

  adf4159_spi_receiver #(.Sync_Stages(2)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipSPI_SClk(ipSPI_SClk),
    .ipSPI_Data(ipSPI_Data), .ipSPI_Latch(ipSPI_Latch), .ipClear(ipClear),
    .opWord(opWord), .opValid(opValid), .opRegs(opRegs),
    .opWordCount(opWordCount), .opFrameError(opFrameError),
    .opErrorSticky(opErrorSticky)
  );

  always #5 ipClk = ~ipClk;

  always @(posedge ipClk) begin
    #1;
    if (opValid === 1'b1) valid_seen++;
    if (opFrameError === 1'b1) ferr_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ipClk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      ipSPI_Data = w[31 - (k % 32)];
      ipSPI_SClk = 1'b0;
      wait_cyc(4);
      ipSPI_SClk = 1'b1;
      wait_cyc(4);
    end
    ipSPI_SClk = 1'b0;
    wait_cyc(2);
  endtask

  task automatic latch_frame();
    ipSPI_Latch = 1'b1;
    wait_cyc(4);
    ipSPI_Latch = 1'b0;
    wait_cyc(6);
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits(w, 32);
    latch_frame();
  endtask

  task automatic test_reset();
    ipReset = 1'b0; ipSPI_SClk = 1'b0; ipSPI_Data = 1'b0;
    ipSPI_Latch = 1'b0; ipClear = 1'b0;
    exp_regs = '0;
    wait_cyc(3);
    checks++;
    if (opWord !== 32'h0 || opValid !== 1'b0 || opFrameError !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: word=%h valid=%b ferr=%b, want 0/0/0", opWord, opValid, opFrameError);
    end
    checks++;
    if (opRegs !== exp_regs || opWordCount !== 16'h0 || opErrorSticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: regs=%h count=%h sticky=%b, want all zero", opRegs, opWordCount, opErrorSticky);
    end
    ipReset = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_good_frame();
    int v0, lat;
    bit found;
    v0 = valid_seen; lat = 0; found = 1'b0;
    send_bits(32'h1234_5670, 32);
    ipSPI_Latch = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge ipClk);
      #1;
      if (opValid === 1'b1) begin
        lat = i; found = 1'b1;
        break;
      end
    end
    wait_cyc(4);
    ipSPI_Latch = 1'b0;
    wait_cyc(6);
    exp_regs.R0 = 32'h1234_5670;
    checks++;
    if (!found || lat != 4) begin
      failures++;
      $display("FAIL good_latency: got %0d cycles (found=%0b), want 4", lat, found);
    end
    checks++;
    if (valid_seen - v0 != 1) begin
      failures++;
      $display("FAIL good_valid_pulses: got %0d, want 1", valid_seen - v0);
    end
    checks++;
    if (opWord !== 32'h1234_5670 || opRegs !== exp_regs) begin
      failures++;
      $display("FAIL good_word: word=%h regs=%h, want word=12345670 regs=%h", opWord, opRegs, exp_regs);
    end
    checks++;
    if (opWordCount !== 16'd1 || opErrorSticky !== 1'b0) begin
      failures++;
      $display("FAIL good_count: count=%0d sticky=%b, want 1/0", opWordCount, opErrorSticky);
    end
  endtask

  task automatic test_bank_select();
    send_frame(32'h0080_0005);
    send_frame(32'h0000_1235);
    send_frame(32'h0000_0044);
    send_frame(32'h0080_0006);
    exp_regs.R5[1] = 32'h0080_0005;
    exp_regs.R5[0] = 32'h0000_1235;
    exp_regs.R4[1] = 32'h0000_0044;
    exp_regs.R6[1] = 32'h0080_0006;
    checks++;
    if (opRegs.R5[1] !== 32'h0080_0005 || opRegs.R5[0] !== 32'h0000_1235) begin
      failures++;
      $display("FAIL bank_r5: b1=%h b0=%h, want 00800005/00001235", opRegs.R5[1], opRegs.R5[0]);
    end
    checks++;
    if (opRegs.R4[1] !== 32'h0000_0044 || opRegs.R4[0] !== 32'h0) begin
      failures++;
      $display("FAIL bank_r4: b1=%h b0=%h, want 00000044/00000000", opRegs.R4[1], opRegs.R4[0]);
    end
    checks++;
    if (opRegs !== exp_regs || opWordCount !== 16'd5) begin
      failures++;
      $display("FAIL bank_regfile: regs=%h count=%0d, want %h count=5", opRegs, opWordCount, exp_regs);
    end
  endtask

  task automatic test_bad_frames();
    int v0, f0;
    v0 = valid_seen; f0 = ferr_seen;
    send_bits(32'hDEAD_BEE1, 31);
    latch_frame();
    send_bits(32'h5555_AAA2, 40);
    latch_frame();
    latch_frame();
    checks++;
    if (ferr_seen - f0 != 3 || valid_seen - v0 != 0) begin
      failures++;
      $display("FAIL bad_pulses: ferr=%0d valid=%0d, want 3/0", ferr_seen - f0, valid_seen - v0);
    end
    checks++;
    if (opErrorSticky !== 1'b1 || opWordCount !== 16'd5) begin
      failures++;
      $display("FAIL bad_status: sticky=%b count=%0d, want 1/5", opErrorSticky, opWordCount);
    end
    checks++;
    if (opRegs !== exp_regs || opWord !== 32'h0080_0006) begin
      failures++;
      $display("FAIL bad_regs: word=%h regs=%h, want word=00800006 regs=%h", opWord, opRegs, exp_regs);
    end
  endtask

  task automatic test_coincident();
    int v0, f0;
    logic [31:0] w;
    w = 32'hCAFE_0002;
    v0 = valid_seen; f0 = ferr_seen;
    send_bits(w, 31);
    ipSPI_Data = w[0];
    ipSPI_SClk = 1'b0;
    wait_cyc(4);
    ipSPI_SClk = 1'b1;
    ipSPI_Latch = 1'b1;
    wait_cyc(4);
    ipSPI_SClk = 1'b0;
    ipSPI_Latch = 1'b0;
    wait_cyc(6);
    exp_regs.R2 = w;
    checks++;
    if (valid_seen - v0 != 1 || ferr_seen - f0 != 0) begin
      failures++;
      $display("FAIL coincident_pulses: valid=%0d ferr=%0d, want 1/0", valid_seen - v0, ferr_seen - f0);
    end
    checks++;
    if (opWord !== w || opRegs !== exp_regs || opWordCount !== 16'd6) begin
      failures++;
      $display("FAIL coincident_commit: word=%h count=%0d, want cafe0002 count=6", opWord, opWordCount);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    v0 = valid_seen; f0 = ferr_seen;
    send_bits(32'hFFFF_0000, 16);
    ipReset = 1'b0;
    wait_cyc(2);
    ipReset = 1'b1;
    wait_cyc(3);
    send_frame(32'hABCD_0003);
    exp_regs = '0;
    exp_regs.R3 = 32'hABCD_0003;
    checks++;
    if (opRegs !== exp_regs || opWord !== 32'hABCD_0003) begin
      failures++;
      $display("FAIL midreset_regs: word=%h regs=%h, want word=abcd0003 regs=%h", opWord, opRegs, exp_regs);
    end
    checks++;
    if (opWordCount !== 16'd1 || opErrorSticky !== 1'b0 || ferr_seen - f0 != 0 || valid_seen - v0 != 1) begin
      failures++;
      $display("FAIL midreset_status: count=%0d sticky=%b ferr=%0d valid=%0d, want 1/0/0/1",
               opWordCount, opErrorSticky, ferr_seen - f0, valid_seen - v0);
    end
  endtask

  task automatic test_saturate_clear();
    force dut.word_count_q = 16'hFFFD;
    #1;
    release dut.word_count_q;
    wait_cyc(1);
    send_frame(32'h0000_0007);
    checks++;
    if (opWordCount !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_step1: count=%h, want fffe", opWordCount);
    end
    send_frame(32'h0000_0011);
    checks++;
    if (opWordCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_full: count=%h, want ffff", opWordCount);
    end
    send_frame(32'h1234_0002);
    checks++;
    if (opWordCount !== 16'hFFFF || opWord !== 32'h1234_0002 || opRegs.R2 !== 32'h1234_0002) begin
      failures++;
      $display("FAIL sat_hold: count=%h word=%h r2=%h, want ffff/12340002/12340002", opWordCount, opWord, opRegs.R2);
    end
    send_bits(32'h0F0F_0F0F, 8);
    latch_frame();
    checks++;
    if (opErrorSticky !== 1'b1 || opWordCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_error: sticky=%b count=%h, want 1/ffff", opErrorSticky, opWordCount);
    end
    ipClear = 1'b1;
    wait_cyc(1);
    ipClear = 1'b0;
    wait_cyc(2);
    checks++;
    if (opWordCount !== 16'h0 || opErrorSticky !== 1'b0 || opWord !== 32'h1234_0002) begin
      failures++;
      $display("FAIL clear: count=%h sticky=%b word=%h, want 0/0/12340002", opWordCount, opErrorSticky, opWord);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bank_select();
    test_bad_frames();
    test_coincident();
    test_reset_mid_frame();
    test_saturate_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
